// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and clock-enable divider width.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RUN    = 3'd4
  } pll_state_e;

  localparam int CE_DIV_W = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage single-bit synchronizer; q lags d by two clk edges, flops cleared by rst_n.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset / lock-qualification sequencer producing core reset and divided clock enables.
// Define PLL_SEQ_TIMEOUT_EN to retry the PLL reset when lock does not arrive within LOCK_TIMEOUT_CYCLES.
import pll_seq_pkg::*;

module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES  = 4800,
  parameter int RESET_HOLD_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 480000,
  parameter int PLLRST_CYCLES       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ce_24m,
  output logic       ce_6m,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > PLLRST_CYCLES) ? LOCK_TIMEOUT_CYCLES : PLLRST_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] LD_PLLRST = CNT_W'(PLLRST_CYCLES);
  localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(RESET_HOLD_CYCLES);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LD_WAIT   = CNT_W'(LOCK_TIMEOUT_CYCLES);
`else
  localparam logic [CNT_W-1:0] LD_WAIT   = '0;
`endif

  pll_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CE_DIV_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [7:0]          lost_q, lost_d;
  logic                lock_s;
  logic                cnt_last;
  logic                ce_run;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // A count of 0 or 1 both mean "this is the final cycle" so a zero parameter still advances.
  assign cnt_last = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q - CNT_W'(1);
    lost_d   = lost_q;
    ce_cnt_d = '0;
    unique case (state_q)
      ST_PLLRST: begin
        if (cnt_last) begin
          state_d = ST_WAIT;
          cnt_d   = LD_WAIT;
        end
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = LD_STABLE;
        end
`ifdef PLL_SEQ_TIMEOUT_EN
        else if (cnt_last) begin
          state_d = ST_PLLRST;
          cnt_d   = LD_PLLRST;
        end
`else
        else begin
          cnt_d = cnt_q;
        end
`endif
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = LD_WAIT;
        end else if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      ST_HOLD: begin
        ce_cnt_d = ce_cnt_q + CE_DIV_W'(1);
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = LD_WAIT;
        end else if (cnt_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ce_cnt_d = ce_cnt_q + CE_DIV_W'(1);
        cnt_d    = cnt_q;
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = LD_WAIT;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_PLLRST;
        cnt_d   = LD_PLLRST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_PLLRST;
      cnt_q    <= LD_PLLRST;
      ce_cnt_q <= '0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ce_cnt_q <= ce_cnt_d;
      lost_q   <= lost_d;
    end
  end

  assign ce_run        = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign pll_rst       = (state_q == ST_PLLRST);
  assign sys_reset     = (state_q != ST_RUN);
  assign ready         = (state_q == ST_RUN);
  assign ce_24m        = ce_run && ce_cnt_q[0];
  assign ce_6m         = ce_run && (ce_cnt_q == '1);
  assign lock_lost_cnt = lost_q;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 4800: cycles pll_locked must stay high before reset release (100 us at 48 MHz).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 1024: cycles sys_reset is held with clock enables running.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 480000: cycles allowed in WAIT before a PLL reset retry.
REQ-004 SHALL have parameter PLLRST_CYCLES, default 16: width of the pll_rst pulse.
REQ-005 SHALL have port clk, input, 1: single 48 MHz system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock, asynchronous to clk.
REQ-008 SHALL have port pll_rst, output, 1: active-high reset request to the PLL.
REQ-009 SHALL have port sys_reset, output, 1: active-high core reset.
REQ-010 SHALL have port ce_24m, output, 1: single-cycle clock enable, 1-in-2.
REQ-011 SHALL have port ce_6m, output, 1: single-cycle clock enable, 1-in-8.
REQ-012 SHALL have port ready, output, 1: high only in RUN.
REQ-013 SHALL have port lock_lost_cnt, output, 8: saturating count of lock losses while in RUN.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; lock_s lags pll_locked by 2 cycles.
REQ-015 SHALL implement FSM states PLLRST, WAIT, STABLE, HOLD, RUN, using a single shared down-counter.
REQ-016 PLLRST SHALL assert pll_rst for exactly PLLRST_CYCLES cycles, then enter WAIT.
REQ-017 WAIT SHALL enter STABLE on lock_s=1 and load LOCK_STABLE_CYCLES.
REQ-018 STABLE SHALL return to WAIT on any lock_s=0, and SHALL enter HOLD when the counter expires with lock_s still 1.
REQ-019 HOLD SHALL keep sys_reset=1, clear the CE divider on entry, run the enables, and enter RUN after RESET_HOLD_CYCLES.
REQ-020 RUN SHALL drive sys_reset=0 and ready=1; on lock_s=0 it SHALL enter WAIT and increment lock_lost_cnt, saturating at 255.
REQ-021 sys_reset SHALL be 1 in every state except RUN, and SHALL deassert on the first RUN cycle.
REQ-022 The CE divider SHALL be a 3-bit counter running only in HOLD and RUN: ce_24m = (cnt[0]==1), ce_6m = (cnt==7); both enables are high in the same cycle when cnt==7.
REQ-023 Outside HOLD and RUN, ce_24m and ce_6m SHALL both be 0.
REQ-024 If lock_s drops on the same cycle a STABLE or HOLD counter expires, the drop SHALL take priority: the FSM enters WAIT.
REQ-025 A lock drop in HOLD SHALL return to WAIT without incrementing lock_lost_cnt.

Reset
REQ-026 While rst_n=0 at a clk edge: state=PLLRST, counter=PLLRST_CYCLES, pll_rst=1, sys_reset=1, ce_24m=0, ce_6m=0, ready=0, lock_lost_cnt=0, synchronizer flops=0.
REQ-027 rst_n assertion mid-operation, including in RUN, SHALL take effect on the next edge and restart the full sequence.

Configuration
REQ-028 Macro PLL_SEQ_TIMEOUT_EN: when defined, WAIT SHALL count LOCK_TIMEOUT_CYCLES and on expiry enter PLLRST (retry).
REQ-029 When PLL_SEQ_TIMEOUT_EN is undefined, WAIT SHALL wait indefinitely, and pll_rst SHALL pulse only after rst_n.

Structure
REQ-030 A shared package pll_seq_pkg SHALL hold the state enum type and the CE divider width constant.
REQ-031 The synchronizer SHALL be sub-module sync_2ff (1-bit, 2-stage, no reset dependency beyond rst_n).

Verification
The bench SHALL use LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=100 and PLLRST_CYCLES=16.
REQ-032 Reset release, then pll_locked=1 at cycle 20 -> pll_rst high in cycles 0-15, STABLE for 8 cycles, HOLD for 4 cycles, sys_reset falls and ready rises at the RUN entry.
REQ-033 In HOLD/RUN -> ce_24m every 2nd cycle, ce_6m every 8th cycle, coinciding with a ce_24m pulse; both 0 in WAIT.
REQ-034 pll_locked glitches low for 1 cycle at STABLE count 5 -> FSM returns to WAIT, and sys_reset never deasserts.
REQ-035 pll_locked never rises, with PLL_SEQ_TIMEOUT_EN defined -> a new 16-cycle pll_rst pulse every 116 cycles; without the macro -> pll_rst stays 0 after the first pulse.
REQ-036 In RUN, drop pll_locked 300 times -> each drop sets sys_reset=1 two cycles later (after the synchronizer), and lock_lost_cnt saturates at 255.
REQ-037 rst_n=0 for 1 cycle in RUN -> all outputs take their reset values on the next edge, and lock_lost_cnt=0.
